// File: rtl/mem_io_responder.sv
// mem_io_responder
//   Memory-side responder for the CPU's byte-wide bus. Each access is decoded
//   as RAM (cpu_a[17:16] != 2'b11) or memory-mapped I/O (cpu_a[17:16] == 2'b11).
//   RAM accesses are forwarded to an external synchronous byte RAM. I/O
//   accesses are serviced here: UART TX FIFO, UART RX pop, a free-running
//   32-bit cycle counter with a coherent 4-byte snapshot, and a sticky stop flag.
//   Read data appears on cpu_din the cycle after the address; writes take one cycle.
//
//   I/O map (cpu_a[17:0]):
//     0x30000  R: pop RX byte (0x00 when RX empty)   W: push nonzero byte to TX FIFO
//     0x30004  R: snapshot counter, return byte 0      W: set program_done, push 0x00
//     0x30005-7 R: snapshot bytes 1..3                 W: no effect
//     other    R: 0x00                                 W: no effect
//
//   Handshake: a TX byte transfers on every rising clk edge where
//   tx_valid & tx_ready are both 1; tx_valid never depends on tx_ready, and
//   tx_data is stable while tx_valid is high and tx_ready is low.
//
//   Ports:
//     clk, rst (async, active-low)          clock and reset
//     rdy                                   bus enable, gates every bus action
//     cpu_a, cpu_wr, cpu_dout / cpu_din     CPU bus
//     io_buffer_full                        registered TX near-full flag
//     ram_a, ram_we, ram_wdata / ram_rdata  external RAM port
//     rx_data, rx_valid / rx_pop            UART RX queue head and pop strobe
//     tx_data, tx_valid / tx_ready          UART TX FIFO head
//     program_done                          sticky stop flag
//
//   Build option: define MEM_IO_CNT_RDY_GATE_EN to make the cycle counter
//   advance only on cycles where rdy = 1.
module mem_io_responder #(
  parameter int RAM_ADDR_W         = 17,
  parameter int TX_FIFO_DEPTH_LOG2 = 3,
  parameter int FULL_MARGIN        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic [31:0]           cpu_a,
  input  logic                  cpu_wr,
  input  logic [7:0]            cpu_dout,
  output logic [7:0]            cpu_din,
  output logic                  io_buffer_full,
  output logic [RAM_ADDR_W-1:0] ram_a,
  output logic                  ram_we,
  output logic [7:0]            ram_wdata,
  input  logic [7:0]            ram_rdata,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_pop,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  program_done
);

  localparam int PW    = TX_FIFO_DEPTH_LOG2;
  localparam int CW    = TX_FIFO_DEPTH_LOG2 + 1;
  localparam int DEPTH = 2 ** TX_FIFO_DEPTH_LOG2;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] MARGIN_C = CW'(FULL_MARGIN);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  localparam logic [17:0] A_UART = 18'h30000;
  localparam logic [17:0] A_CNT0 = 18'h30004;
  localparam logic [17:0] A_CNT1 = 18'h30005;
  localparam logic [17:0] A_CNT2 = 18'h30006;
  localparam logic [17:0] A_CNT3 = 18'h30007;

  logic [17:0] io_a;
  logic        is_io;
  logic        rd_cyc;
  logic        wr_cyc;
  logic        unused_hi;

  assign io_a      = cpu_a[17:0];
  assign is_io     = (cpu_a[17:16] == 2'b11);
  assign rd_cyc    = rdy & ~cpu_wr;
  assign wr_cyc    = rdy & cpu_wr;
  assign unused_hi = ^cpu_a[31:18];

  // RAM port
  assign ram_a     = cpu_a[RAM_ADDR_W-1:0];
  assign ram_we    = wr_cyc & ~is_io;
  assign ram_wdata = cpu_dout;

  assign rx_pop = rd_cyc & (io_a == A_UART) & rx_valid;

  // Cycle counter
  logic [31:0] cycle_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt_q <= 32'd0;
    end else begin
`ifdef MEM_IO_CNT_RDY_GATE_EN
      if (rdy) cycle_cnt_q <= cycle_cnt_q + 32'd1;
`else
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
`endif
    end
  end

  // Read path. sel_io_q resets to 1 so cpu_din shows the cleared
  // io_rdata_q rather than whatever the external RAM drives.
  logic        sel_io_q;
  logic [7:0]  io_rdata_q;
  logic [31:0] snapshot_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_io_q   <= 1'b1;
      io_rdata_q <= 8'h00;
      snapshot_q <= 32'd0;
    end else if (rd_cyc) begin
      sel_io_q <= is_io;
      if (is_io) begin
        case (io_a)
          A_UART:  io_rdata_q <= rx_valid ? rx_data : 8'h00;
          A_CNT0: begin
            snapshot_q <= cycle_cnt_q;
            io_rdata_q <= cycle_cnt_q[7:0];
          end
          // Upper bytes come from the snapshot so a 4-read sequence is coherent.
          A_CNT1:  io_rdata_q <= snapshot_q[15:8];
          A_CNT2:  io_rdata_q <= snapshot_q[23:16];
          A_CNT3:  io_rdata_q <= snapshot_q[31:24];
          default: io_rdata_q <= 8'h00;
        endcase
      end
    end
  end

  assign cpu_din = sel_io_q ? io_rdata_q : ram_rdata;

  // TX FIFO
  logic [7:0]    fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_next;
  logic [CW-1:0] free_next;
  logic          push_req;
  logic [7:0]    push_data;
  logic          push_ok;
  logic          pop;

  assign push_req  = wr_cyc & (((io_a == A_UART) & (cpu_dout != 8'h00)) | (io_a == A_CNT0));
  assign push_data = (io_a == A_CNT0) ? 8'h00 : cpu_dout;
  assign pop       = tx_valid & tx_ready;
  // A simultaneous pop frees the head slot, so a push at full is still accepted.
  assign push_ok   = push_req & ((count_q != DEPTH_C) | pop);

  always_comb begin
    count_next = count_q;
    case ({push_ok, pop})
      2'b10:   count_next = count_q + CNT_ONE;
      2'b01:   count_next = count_q - CNT_ONE;
      default: count_next = count_q;
    endcase
  end

  assign free_next = DEPTH_C - count_next;

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      io_buffer_full <= 1'b0;
      program_done   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q        <= count_next;
      io_buffer_full <= (free_next <= MARGIN_C);
      if (wr_cyc && (io_a == A_CNT0)) program_done <= 1'b1;
    end
  end

  assign tx_data  = fifo_mem[rd_ptr_q];
  assign tx_valid = (count_q != '0);

endmodule

// File: tb/tb_mem_io_responder.sv
// Testbench for mem_io_responder: randomized bus traffic checked against a
// behavioural model (RAM contents array, TX byte queue, cycles-since-reset count).
module tb_mem_io_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [31:0] cpu_a;
  logic        cpu_wr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        io_buffer_full;
  logic [16:0] ram_a;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_pop;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        program_done;

  int errors = 0;
  int checks = 0;

  mem_io_responder dut (
    .clk(clk), .rst(rst), .rdy(rdy), .cpu_a(cpu_a), .cpu_wr(cpu_wr),
    .cpu_dout(cpu_dout), .cpu_din(cpu_din), .io_buffer_full(io_buffer_full),
    .ram_a(ram_a), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .program_done(program_done)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // External synchronous RAM seen by the DUT
  logic [7:0] ram_mem [0:131071];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_a] <= ram_wdata;
    ram_rdata <= ram_mem[ram_a];
  end

  int we_cnt = 0;
  always @(posedge clk) if (ram_we) we_cnt <= we_cnt + 1;

  // ---------------- reference model ----------------
  logic [7:0]  ram_m [int];   // RAM contents written over the bus
  logic [7:0]  exp_q [$];     // bytes expected out of the TX port, in order
  logic [31:0] cnt_m;         // clock edges since reset release

  always @(posedge clk or negedge rst) begin
    if (!rst) cnt_m <= 32'd0;
`ifdef MEM_IO_CNT_RDY_GATE_EN
    else if (rdy) cnt_m <= cnt_m + 32'd1;
`else
    else cnt_m <= cnt_m + 32'd1;
`endif
  end

  // ---------------- driver tasks ----------------
  // Writes assume tx_ready = 0, so a push is accepted only below depth 8.
  task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_a = a; cpu_wr = 1'b1; cpu_dout = d; rdy = 1'b1;
    @(posedge clk);
    if (a[17:16] != 2'b11) ram_m[int'(a[16:0])] = d;
    else if ((a[17:0] == 18'h30000 && d != 8'h00) || a[17:0] == 18'h30004) begin
      if (exp_q.size() < 8) exp_q.push_back((a[17:0] == 18'h30004) ? 8'h00 : d);
    end
    #1 rdy = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [7:0] d);
    @(negedge clk);
    cpu_a = a; cpu_wr = 1'b0; rdy = 1'b1;
    @(posedge clk);
    #1 rdy = 1'b0;
    @(negedge clk);
    d = cpu_din;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; rdy = 1'b0; cpu_a = 32'd0; cpu_wr = 1'b0; cpu_dout = 8'h00;
    rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (cpu_din !== 8'h00) begin errors++; $display("FAIL reset_cpu_din: got %h expected 00", cpu_din); end
    checks++; if (io_buffer_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", io_buffer_full); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we: got %b expected 0", ram_we); end
    checks++; if (rx_pop !== 1'b0) begin errors++; $display("FAIL reset_rx_pop: got %b expected 0", rx_pop); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    checks++; if (program_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", program_done); end
    rst = 1'b1;
  endtask

  task automatic test_ram();
    logic [31:0] addr [6];
    logic [31:0] hi;
    logic [7:0]  r;
    int          we0;
    we0 = we_cnt;
    bus_write(32'h0000_0010, 8'hA5);
    checks++; if (we_cnt - we0 !== 1) begin errors++; $display("FAIL ram_we_pulse: got %0d expected 1", we_cnt - we0); end
    bus_read(32'h0000_0010, r);
    checks++; if (r !== 8'hA5) begin errors++; $display("FAIL ram_a5: got %h expected a5", r); end
    we0 = we_cnt;
    for (int i = 0; i < 6; i++) begin
      hi = $urandom;
      addr[i] = {hi[13:0], 18'($urandom_range(32'h20, 32'h2FFFF))};
      bus_write(addr[i], 8'($urandom_range(0, 255)));
    end
    checks++; if (we_cnt - we0 !== 6) begin errors++; $display("FAIL ram_we_count: got %0d expected 6", we_cnt - we0); end
    for (int i = 0; i < 6; i++) begin
      bus_read(addr[i], r);
      checks++; if (r !== ram_m[int'(addr[i][16:0])]) begin errors++; $display("FAIL ram_rand: addr %h got %h expected %h", addr[i], r, ram_m[int'(addr[i][16:0])]); end
    end
  endtask

  task automatic test_uart_out();
    tx_ready = 1'b0;
    bus_write(32'h30000, 8'h48);
    bus_write(32'h30000, 8'h00);
    bus_write(32'h30008, 8'h77);
    bus_write(32'h30000, 8'h69);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h48) begin errors++; $display("FAIL uart_head: got v=%b d=%h expected v=1 d=48", tx_valid, tx_data); end
  endtask

  task automatic test_drain();
    @(negedge clk);
    tx_ready = 1'b1;
    while (exp_q.size() != 0) begin
      checks++; if (tx_valid !== 1'b1 || tx_data !== exp_q[0]) begin errors++; $display("FAIL drain: got v=%b d=%h expected v=1 d=%h", tx_valid, tx_data, exp_q[0]); end
      @(posedge clk);
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    tx_ready = 1'b0;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b expected 0", tx_valid); end
    checks++; if (io_buffer_full !== 1'b0) begin errors++; $display("FAIL drain_full_flag: got %b expected 0", io_buffer_full); end
  endtask

  task automatic test_full();
    logic [7:0] x;
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bus_write(32'h30000, 8'($urandom_range(1, 255)));
      if (i == 4) begin
        checks++; if (io_buffer_full !== 1'b0) begin errors++; $display("FAIL full_at5: got %b expected 0", io_buffer_full); end
      end
      if (i == 5) begin
        checks++; if (io_buffer_full !== 1'b1) begin errors++; $display("FAIL full_at6: got %b expected 1", io_buffer_full); end
      end
    end
    checks++; if (io_buffer_full !== 1'b1) begin errors++; $display("FAIL full_at8: got %b expected 1", io_buffer_full); end
    // push and pop together while full
    x = 8'($urandom_range(1, 255));
    @(negedge clk);
    tx_ready = 1'b1; cpu_a = 32'h30000; cpu_wr = 1'b1; cpu_dout = x; rdy = 1'b1;
    checks++; if (tx_valid !== 1'b1 || tx_data !== exp_q[0]) begin errors++; $display("FAIL pushpop_head: got v=%b d=%h expected v=1 d=%h", tx_valid, tx_data, exp_q[0]); end
    @(posedge clk);
    void'(exp_q.pop_front());
    exp_q.push_back(x);
    #1 rdy = 1'b0; cpu_wr = 1'b0; tx_ready = 1'b0;
    checks++; if (io_buffer_full !== 1'b1) begin errors++; $display("FAIL pushpop_full: got %b expected 1", io_buffer_full); end
  endtask

  task automatic test_rx();
    logic [7:0] d;
    logic       v;
    logic [7:0] r;
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom_range(1, 255));
      v = (i % 2 == 0);
      rx_data = d; rx_valid = v;
      @(negedge clk);
      cpu_a = 32'h30000; cpu_wr = 1'b0; rdy = 1'b1;
      #1;
      checks++; if (rx_pop !== v) begin errors++; $display("FAIL rx_pop: got %b expected %b", rx_pop, v); end
      @(posedge clk);
      #1 rdy = 1'b0; rx_valid = 1'b0;
      @(negedge clk);
      checks++; if (cpu_din !== (v ? d : 8'h00)) begin errors++; $display("FAIL rx_data: got %h expected %h", cpu_din, (v ? d : 8'h00)); end
    end
    rx_data = 8'h5A; rx_valid = 1'b1;
    bus_read(32'h30002, r);
    rx_valid = 1'b0;
    checks++; if (r !== 8'h00) begin errors++; $display("FAIL io_other_a: got %h expected 00", r); end
    bus_read(32'($urandom_range(32'h30008, 32'h3FFFF)), r);
    checks++; if (r !== 8'h00) begin errors++; $display("FAIL io_other_b: got %h expected 00", r); end
  endtask

  task automatic test_counter();
    logic [31:0] exp;
    logic [7:0]  r;
    exp = 32'd0;
    repeat (1000) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k > 0) begin
        checks++; if (cpu_din !== exp[8*(k-1) +: 8]) begin errors++; $display("FAIL cnt_byte%0d: got %h expected %h", k - 1, cpu_din, exp[8*(k-1) +: 8]); end
      end
      cpu_a = 32'h30004 + 32'(k); cpu_wr = 1'b0; rdy = 1'b1;
      if (k == 0) exp = cnt_m;
      @(posedge clk);
    end
    #1 rdy = 1'b0;
    @(negedge clk);
    checks++; if (cpu_din !== exp[31:24]) begin errors++; $display("FAIL cnt_byte3: got %h expected %h", cpu_din, exp[31:24]); end
    repeat (20) @(negedge clk);
    bus_read(32'h30005, r);
    checks++; if (r !== exp[15:8]) begin errors++; $display("FAIL cnt_coherent: got %h expected %h", r, exp[15:8]); end
  endtask

  task automatic test_rdy_gating();
    logic [7:0]  d1;
    logic [7:0]  r;
    logic [31:0] exp;
    d1 = 8'($urandom_range(1, 255));
    rx_data = d1; rx_valid = 1'b1;
    bus_read(32'h30000, r);
    checks++; if (r !== d1) begin errors++; $display("FAIL gate_pre: got %h expected %h", r, d1); end
    tx_ready = 1'b0;
    @(negedge clk);
    cpu_a = 32'h30000; cpu_wr = 1'b1; cpu_dout = 8'h55; rdy = 1'b0;
    @(negedge clk);
    cpu_a = 32'h00020;
    #1;
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL gate_ram_we: got %b expected 0", ram_we); end
    @(negedge clk);
    cpu_a = 32'h30000; cpu_wr = 1'b0; rx_data = 8'($urandom_range(1, 255));
    #1;
    checks++; if (rx_pop !== 1'b0) begin errors++; $display("FAIL gate_rx_pop: got %b expected 0", rx_pop); end
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    checks++; if (cpu_din !== d1) begin errors++; $display("FAIL gate_hold: got %h expected %h", cpu_din, d1); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL gate_no_push: got %b expected 0", tx_valid); end
    cpu_a = 32'h30004; cpu_wr = 1'b0; rdy = 1'b1;
    exp = cnt_m;
    @(posedge clk);
    #1 rdy = 1'b0;
    @(negedge clk);
    checks++; if (cpu_din !== exp[7:0]) begin errors++; $display("FAIL gate_cnt: got %h expected %h", cpu_din, exp[7:0]); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.cycle_cnt_q = 32'hFFFF_FFFF;
    release dut.cycle_cnt_q;
    cpu_a = 32'h30004; cpu_wr = 1'b0; rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (cpu_din !== 8'hFF) begin errors++; $display("FAIL wrap_b0: got %h expected ff", cpu_din); end
    cpu_a = 32'h30007;
    @(posedge clk);
    @(negedge clk);
    checks++; if (cpu_din !== 8'hFF) begin errors++; $display("FAIL wrap_b3: got %h expected ff", cpu_din); end
    cpu_a = 32'h30004;
    @(posedge clk);
    #1 rdy = 1'b0;
    @(negedge clk);
    checks++; if (cpu_din !== 8'h01) begin errors++; $display("FAIL wrap_next: got %h expected 01", cpu_din); end
  endtask

  task automatic test_stop_reset();
    logic [7:0] d;
    logic [7:0] r;
    d = 8'($urandom_range(1, 255));
    tx_ready = 1'b0;
    rx_data = d; rx_valid = 1'b1;
    bus_read(32'h30000, r);
    rx_valid = 1'b0;
    checks++; if (r !== d) begin errors++; $display("FAIL stop_pre: got %h expected %h", r, d); end
    bus_write(32'h30000, 8'h41);
    bus_write(32'h30004, 8'($urandom_range(0, 255)));
    checks++; if (program_done !== 1'b1) begin errors++; $display("FAIL stop_done: got %b expected 1", program_done); end
    @(negedge clk);
    tx_ready = 1'b1;
    checks++; if (tx_valid !== 1'b1 || tx_data !== exp_q[0]) begin errors++; $display("FAIL stop_first: got v=%b d=%h expected v=1 d=%h", tx_valid, tx_data, exp_q[0]); end
    @(posedge clk);
    void'(exp_q.pop_front());
    @(negedge clk);
    checks++; if (tx_valid !== 1'b1 || tx_data !== exp_q[0]) begin errors++; $display("FAIL stop_term: got v=%b d=%h expected v=1 d=%h", tx_valid, tx_data, exp_q[0]); end
    checks++; if (cpu_din !== d) begin errors++; $display("FAIL stop_din_pre: got %h expected %h", cpu_din, d); end
    #3 rst = 1'b0;
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL arst_tx_valid: got %b expected 0", tx_valid); end
    checks++; if (program_done !== 1'b0) begin errors++; $display("FAIL arst_done: got %b expected 0", program_done); end
    checks++; if (cpu_din !== 8'h00) begin errors++; $display("FAIL arst_din: got %h expected 00", cpu_din); end
    exp_q.delete();
    tx_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0 || io_buffer_full !== 1'b0) begin errors++; $display("FAIL post_reset: got v=%b full=%b expected 0 0", tx_valid, io_buffer_full); end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_ram();
    test_uart_out();
    test_drain();
    test_full();
    test_drain();
    test_rx();
    test_counter();
    test_rdy_gating();
    test_wrap();
    test_stop_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Memory-side responder for the CPU's byte-wide bus (address, write-enable, data-out in; data-in back).
- Decodes each access as either RAM or memory-mapped I/O.
- RAM accesses go to a synchronous 128 KB byte RAM.
- I/O accesses are serviced internally:
  - UART TX FIFO,
  - UART RX pop,
  - free-running cycle counter,
  - program-stop flag.
- Read data is returned one cycle after the address; writes complete in one cycle.

Parameters:
- RAM_ADDR_W, 17, byte-address width of the RAM port.
- TX_FIFO_DEPTH_LOG2, 3, TX FIFO depth is 2**N entries (8).
- FULL_MARGIN, 2, free entries at or below which io_buffer_full asserts.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- rdy  in  1  bus enable; accesses ignored when low
- cpu_a  in  32  CPU address; only [17:0] used
- cpu_wr  in  1  1 = write, 0 = read
- cpu_dout  in  8  CPU write data
- cpu_din  out  8  read data to CPU, valid the cycle after the address
- io_buffer_full  out  1  TX FIFO near-full indication to CPU
- ram_a  out  RAM_ADDR_W  RAM byte address (combinational from cpu_a)
- ram_we  out  1  RAM write strobe
- ram_wdata  out  8  RAM write data
- ram_rdata  in  8  RAM read data, one cycle after ram_a
- rx_data  in  8  UART receive byte at head of RX queue
- rx_valid  in  1  RX queue non-empty
- rx_pop  out  1  one-cycle pop of RX queue
- tx_data  out  8  TX FIFO head byte
- tx_valid  out  1  TX FIFO non-empty
- tx_ready  in  1  UART accepts head byte when tx_valid & tx_ready
- program_done  out  1  sticky stop flag

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. All state clears on rst low regardless of clk or rdy.
- Reset values:
  - cpu_din = 0, io_buffer_full = 0, ram_we = 0, rx_pop = 0, tx_valid = 0, program_done = 0.
  - Cycle counter = 0; TX FIFO empty; snapshot register = 0.
- Decode: is_io = (cpu_a[17:16] == 2'b11). Non-I/O accesses go to RAM using cpu_a[RAM_ADDR_W-1:0].
- Gating: every action below is qualified by rdy. When rdy is low:
  - ram_we = 0 and rx_pop = 0.
  - No FIFO push.
  - Select and read registers hold their values.
- RAM write: ram_we = rdy & cpu_wr & ~is_io, ram_wdata = cpu_dout, combinational.
- Read path:
  - Registered flag sel_io_q <= is_io on every rdy read cycle.
  - cpu_din = sel_io_q ? io_rdata_q : ram_rdata.
  - Latency is exactly 1 cycle for both RAM and I/O.
- I/O read 0x30000:
  - io_rdata_q <= rx_valid ? rx_data : 8'h00.
  - rx_pop pulses in the same cycle only if rx_valid.
- I/O read 0x30004:
  - Snapshot <= counter and io_rdata_q <= counter[7:0], both in the same edge.
- I/O read 0x30005/6/7: io_rdata_q <= snapshot byte 1/2/3. The snapshot is not reloaded, so the 4 bytes are coherent.
- Other I/O read addresses return 8'h00.
- I/O write 0x30000:
  - Nonzero data pushes into the TX FIFO; 8'h00 is ignored.
  - Push while the FIFO is full drops the byte; FIFO contents are unchanged.
- I/O write 0x30004:
  - Sets program_done (sticky until reset).
  - Pushes 8'h00 into the TX FIFO as terminator, subject to the same full rule.
- Other I/O write addresses: no effect.
- TX FIFO:
  - Circular buffer with wrap-around pointers and a count of width TX_FIFO_DEPTH_LOG2+1.
  - Pop on tx_valid & tx_ready.
  - Push and pop in the same cycle: count unchanged, both pointers advance. This holds even when full, because the pop frees the slot first, so the push is accepted.
  - tx_data = mem[rd_ptr]; tx_valid = (count != 0).
- io_buffer_full is registered: 1 when (2**N − count_next) <= FULL_MARGIN, else 0.
- Cycle counter: 32-bit, +1 every clk after reset release, wraps 0xFFFFFFFF→0.

Optional Feature:
- Macro: MEM_IO_CNT_RDY_GATE_EN.
- Defined: the cycle counter increments only when rdy = 1, so it counts CPU-active cycles.
- Undefined: the counter increments on every clock regardless of rdy.

Test Plan:
- RAM write/read: write 0xA5 to 0x00010 with rdy=1, then read 0x00010 → ram_we pulses once; cpu_din = 0xA5 exactly 1 cycle after the read address.
- UART out:
  - Write 0x48, 0x00, 0x69 to 0x30000 with tx_ready=0 → FIFO count = 2 (zero ignored).
  - Raise tx_ready → tx_data sequence is 0x48 then 0x69; tx_valid then drops.
- Full/backpressure (tx_ready=0, FULL_MARGIN=2, depth 8):
  - Push 6 bytes → io_buffer_full = 1 the cycle after the 6th push.
  - Push 3 more → count = 8; the 9th byte is dropped.
  - Push and pop in the same cycle at full → count stays 8 and the new byte appears last.
- Cycle counter:
  - After 1000 cycles, read 0x30004–0x30007 on consecutive cycles → bytes equal the snapshot taken at the 0x30004 read (1000 ± pipeline offset), with byte 3 = 0.
  - Force the counter to 0xFFFFFFFF → next value 0.
- Stop and reset:
  - Write to 0x30004 → program_done = 1 and 0x00 is queued.
  - Assert rst low mid-drain, asynchronously between edges → tx_valid, program_done and cpu_din go to 0 immediately.
- rdy gating: hold rdy=0 during a write to 0x30000 and a read to 0x30000 with rx_valid=1 → no push, rx_pop stays 0, cpu_din holds its previous value; the counter follows MEM_IO_CNT_RDY_GATE_EN.
